// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit synchronous memory port between the fx68k bus and the SPI loader word stream.
// Optional SPI read-back path is built when MEM_ARB_SPI_READ_EN is defined.
module mem_port_arbiter #(
    parameter int C_ADDR_BITS = 23,
    parameter int C_LATENCY   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_as_n,
    input  logic                   cpu_rw,
    input  logic                   cpu_uds_n,
    input  logic                   cpu_lds_n,
    input  logic [C_ADDR_BITS-1:0] cpu_a,
    input  logic [15:0]            cpu_dout,
    output logic [15:0]            cpu_din,
    output logic                   dtack_n,
    input  logic                   spi_wr,
    input  logic [C_ADDR_BITS-1:0] spi_addr,
    input  logic [15:0]            spi_data,
    output logic                   spi_busy,
    output logic                   spi_overrun,
`ifdef MEM_ARB_SPI_READ_EN
    input  logic                   spi_rd,
    output logic [15:0]            spi_rdata,
    output logic                   spi_rvalid,
`endif
    output logic [C_ADDR_BITS-1:0] mem_addr,
    output logic [15:0]            mem_din,
    output logic                   mem_we,
    output logic                   mem_re,
    output logic                   mem_ub,
    output logic                   mem_lb,
    input  logic [15:0]            mem_dout
);

    localparam logic [3:0] LAT    = 4'(C_LATENCY);
    localparam logic [3:0] LAT_M1 = 4'(C_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_ACC  = 2'd1,
        ST_CPU_HOLD = 2'd2,
        ST_SPI_ACC  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   last_cpu_q, last_cpu_d;
    logic                   abort_q, abort_d;
    logic                   dtack_n_q, dtack_n_d;
    logic [15:0]            cpu_din_q, cpu_din_d;
    logic [C_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]            mem_din_q, mem_din_d;
    logic                   mem_we_q, mem_we_d;
    logic                   mem_re_q, mem_re_d;
    logic                   mem_ub_q, mem_ub_d;
    logic                   mem_lb_q, mem_lb_d;
    logic                   hold_full_q, hold_full_d;
    logic [C_ADDR_BITS-1:0] hold_addr_q, hold_addr_d;
    logic [15:0]            hold_data_q, hold_data_d;
    logic                   overrun_q, overrun_d;
    logic                   spi_done_s;
    logic                   spi_rd_s;
    logic                   hold_rd_s;

`ifdef MEM_ARB_SPI_READ_EN
    logic                   hold_rd_q, hold_rd_d;
    logic [15:0]            spi_rdata_q, spi_rdata_d;
    logic                   spi_rvalid_q, spi_rvalid_d;

    assign spi_rd_s  = spi_rd;
    assign hold_rd_s = hold_rd_q;
`else
    assign spi_rd_s  = 1'b0;
    assign hold_rd_s = 1'b0;
`endif

    // Next-state, memory strobes and SPI holding register
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_cpu_d  = last_cpu_q;
        abort_d     = abort_q;
        dtack_n_d   = dtack_n_q;
        cpu_din_d   = cpu_din_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;
        mem_re_d    = mem_re_q;
        mem_ub_d    = mem_ub_q;
        mem_lb_d    = mem_lb_q;
        hold_full_d = hold_full_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        overrun_d   = overrun_q;
        spi_done_s  = 1'b0;
`ifdef MEM_ARB_SPI_READ_EN
        hold_rd_d    = hold_rd_q;
        spi_rdata_d  = spi_rdata_q;
        spi_rvalid_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d   = 4'd0;
                abort_d = 1'b0;
                // A pending SPI word wins when the CPU is idle or had the last turn
                if (hold_full_q && (cpu_as_n || last_cpu_q)) begin
                    state_d    = ST_SPI_ACC;
                    mem_addr_d = hold_addr_q;
                    mem_din_d  = hold_data_q;
                    mem_we_d   = ~hold_rd_s;
                    mem_re_d   = hold_rd_s;
                    mem_ub_d   = 1'b1;
                    mem_lb_d   = 1'b1;
                end else if (!cpu_as_n) begin
                    state_d    = ST_CPU_ACC;
                    mem_addr_d = cpu_a;
                    mem_din_d  = cpu_dout;
                    mem_we_d   = ~cpu_rw;
                    mem_re_d   = cpu_rw;
                    mem_ub_d   = ~cpu_uds_n;
                    mem_lb_d   = ~cpu_lds_n;
                end else begin
                    mem_re_d = 1'b0;
                    mem_ub_d = 1'b0;
                    mem_lb_d = 1'b0;
                end
            end
            ST_CPU_ACC: begin
                if (cnt_q == LAT) begin
                    mem_re_d   = 1'b0;
                    mem_ub_d   = 1'b0;
                    mem_lb_d   = 1'b0;
                    last_cpu_d = 1'b1;
                    // A strobe released mid-access means the CPU abandoned the cycle
                    if (abort_q || cpu_as_n) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_CPU_HOLD;
                        dtack_n_d = 1'b0;
                        if (mem_re_q) begin
                            cpu_din_d = mem_dout;
                        end else begin
                            cpu_din_d = cpu_din_q;
                        end
                    end
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    abort_d = abort_q | cpu_as_n;
                end
            end
            ST_CPU_HOLD: begin
                if (cpu_as_n) begin
                    dtack_n_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_CPU_HOLD;
                end
            end
            ST_SPI_ACC: begin
                // Reads wait one extra cycle so the returned word can be captured
                if (cnt_q == (hold_rd_s ? LAT : LAT_M1)) begin
                    spi_done_s = 1'b1;
                    mem_re_d   = 1'b0;
                    mem_ub_d   = 1'b0;
                    mem_lb_d   = 1'b0;
                    last_cpu_d = 1'b0;
                    state_d    = ST_IDLE;
`ifdef MEM_ARB_SPI_READ_EN
                    if (hold_rd_q) begin
                        spi_rdata_d  = mem_dout;
                        spi_rvalid_d = 1'b1;
                    end else begin
                        spi_rdata_d  = spi_rdata_q;
                        spi_rvalid_d = 1'b0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                dtack_n_d = 1'b1;
                mem_re_d  = 1'b0;
                mem_ub_d  = 1'b0;
                mem_lb_d  = 1'b0;
            end
        endcase

        // The slot freed this cycle may be refilled by a request arriving now
        if (spi_done_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
        if (spi_wr || spi_rd_s) begin
            if (!hold_full_q || spi_done_s) begin
                hold_full_d = 1'b1;
                hold_addr_d = spi_addr;
                hold_data_d = spi_data;
`ifdef MEM_ARB_SPI_READ_EN
                hold_rd_d   = ~spi_wr & spi_rd;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            last_cpu_q  <= 1'b0;
            abort_q     <= 1'b0;
            dtack_n_q   <= 1'b1;
            cpu_din_q   <= 16'd0;
            mem_addr_q  <= '0;
            mem_din_q   <= 16'd0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_ub_q    <= 1'b0;
            mem_lb_q    <= 1'b0;
            hold_full_q <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= 16'd0;
            overrun_q   <= 1'b0;
`ifdef MEM_ARB_SPI_READ_EN
            hold_rd_q    <= 1'b0;
            spi_rdata_q  <= 16'd0;
            spi_rvalid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_cpu_q  <= last_cpu_d;
            abort_q     <= abort_d;
            dtack_n_q   <= dtack_n_d;
            cpu_din_q   <= cpu_din_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_ub_q    <= mem_ub_d;
            mem_lb_q    <= mem_lb_d;
            hold_full_q <= hold_full_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            overrun_q   <= overrun_d;
`ifdef MEM_ARB_SPI_READ_EN
            hold_rd_q    <= hold_rd_d;
            spi_rdata_q  <= spi_rdata_d;
            spi_rvalid_q <= spi_rvalid_d;
`endif
        end
    end

    assign cpu_din     = cpu_din_q;
    assign dtack_n     = dtack_n_q;
    assign spi_busy    = hold_full_q;
    assign spi_overrun = overrun_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign mem_ub      = mem_ub_q;
    assign mem_lb      = mem_lb_q;
`ifdef MEM_ARB_SPI_READ_EN
    assign spi_rdata   = spi_rdata_q;
    assign spi_rvalid  = spi_rvalid_q;
`endif

endmodule
